led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
- Time-multiplexed column scanner for an LED dot matrix of ROWS x COLS pixels.
- Holds a double-buffered frame and steps through the columns at a programmable rate. For each column it drives the row pattern and a one-hot column enable.
- Replaces the free-standing per-row multiplexer plus external select counter. Adds an internal scan counter, a prescaler, anti-ghost blanking and a tear-free frame swap at the frame boundary.

Parameters:
- ROWS, 5, rows per column (row output width).
- COLS, 7, columns scanned per frame.
- DIV, 50000, clock cycles each column stays selected; must be >= 2.
- BLANK, 2, cycles at the start of each column slot during which rows are forced to 0; must be < DIV.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_in  in  ROWS*COLS  new frame; pixel (c,r) = frame_in[c*ROWS + r].
- load  in  1  one-cycle strobe that captures frame_in into the shadow buffer.
- enable  in  1  1 = scan runs; 0 = scan frozen, display dark.
- rows  out  ROWS  row drive for the selected column, active-high.
- cols  out  COLS  one-hot column enable, active-high.
- col_idx  out  clog2(COLS)  index of the column currently selected internally.
- frame_done  out  1  one-cycle pulse when the scan wraps from COLS-1 to 0.
- pending  out  1  shadow holds a frame not yet displayed.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset state (cycle after rst is sampled high):
  - prescaler cnt = 0, col_idx = 0.
  - Active and shadow buffers all 0.
  - pending = 0, rows = 0, cols = 0, frame_done = 0.
  - rst overrides every other input. Reset mid-frame discards any pending frame.
- Prescaler:
  - While enable = 1, cnt runs 0..DIV-1 and wraps.
  - tick = enable & (cnt == DIV-1).
  - While enable = 0, cnt and col_idx hold their values. The scan resumes from the same point when enable returns to 1.
- Column step:
  - On tick, col_idx <= col_idx+1.
  - At COLS-1 it wraps to 0; that cycle is a "wrap tick".
  - COLS need not be a power of 2. col_idx never exceeds COLS-1.
- frame_done: registered. It is 1 exactly in the cycle after a wrap tick, otherwise 0.
- Load and swap:
  - load=1 without a wrap tick: shadow <= frame_in, pending <= 1.
  - Wrap tick with pending=1: active <= shadow, pending <= 0.
  - load coinciding with a wrap tick: active <= frame_in directly, shadow <= frame_in, pending <= 0 (newest data wins).
  - Repeated loads before the swap overwrite the shadow; only the last one is displayed.
  - The active buffer never changes except at a wrap tick, so no torn frames.
- Outputs: registered, 1-cycle latency from internal state.
  - cols <= enable ? (1 << col_idx) : 0.
  - rows <= (enable & cnt >= BLANK) ? active[col_idx*ROWS +: ROWS] : 0.
  - Consequence: each column slot shows BLANK dark cycles, then DIV-BLANK lit cycles.
  - BLANK = 0 disables blanking.
- One-hot guarantee: cols has at most one bit set in every cycle. It is all-zero when enable=0 or during reset.
- Frame period: COLS*DIV enabled cycles; frame_done fires once per period.

Test Plan (ROWS=5, COLS=7, DIV=4, BLANK=1 unless stated):
1. Reset, then enable=1, active all 0 -> cols steps 0000001 -> 0000010 ... -> 1000000 -> 0000001, each held 4 cycles. col_idx follows 0..6..0. frame_done pulses once every 28 cycles. rows stays 0.
2. Load frame_in with column 2 = 5'b10101 and all other columns 0, then wait for a wrap tick -> pending=1 until the wrap, then 0. During col 2 slots, rows = 00000 for 1 cycle, then 10101 for 3 cycles. All other slots show rows=0.
3. Assert load on the exact wrap-tick cycle with column 0 = 5'b11111 -> pending stays 0. The column-0 slot starting next shows rows=11111 after 1 blank cycle.
4. Load frame A mid-frame, then frame B two cycles later, before the wrap -> after the wrap only B is displayed; A never appears on rows.
5. Drop enable for 10 cycles during column 4, cnt=2 -> rows=0 and cols=0 during the gap (one cycle after enable falls). After enable=1, column 4 resumes with the remaining 2 cycles of its slot before advancing to column 5.
6. Assert rst while pending=1 at column 5 -> next cycle: col_idx=0, pending=0, rows=0, cols=0. The first lit frame after release is all-dark until a new load.

Source files
------------

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: frame/control/display bundle for the LED matrix scanner.
//   master : drives frame_in, load, enable; observes the display outputs.
//   slave  : the scanner; consumes frame/control, drives rows, cols, col_idx,
//            frame_done, pending.
`timescale 1ns/1ps
interface led_matrix_scanner_if #(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 7
);
  localparam int unsigned NPIX = ROWS * COLS;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;

  logic [NPIX-1:0] frame_in;   // pixel (c,r) at bit c*ROWS + r
  logic            load;       // one-cycle capture strobe for frame_in
  logic            enable;     // 1 = scan runs, 0 = frozen and dark
  logic [ROWS-1:0] rows;       // row drive for the selected column
  logic [COLS-1:0] cols;       // one-hot column enable
  logic [CW-1:0]   col_idx;    // internally selected column
  logic            frame_done; // pulse in the cycle after a wrap
  logic            pending;    // shadow holds an undisplayed frame

  modport master (
    output frame_in, load, enable,
    input  rows, cols, col_idx, frame_done, pending
  );

  modport slave (
    input  frame_in, load, enable,
    output rows, cols, col_idx, frame_done, pending
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: time-multiplexed column scanner for a ROWS x COLS LED
// dot matrix with a double-buffered frame.
//   clk  : system clock, rising edge.
//   rst  : synchronous active-high reset, overrides all other inputs.
//   bus  : led_matrix_scanner_if.slave
//          in  frame_in, load, enable
//          out rows, cols, col_idx, frame_done, pending
// Each column stays selected for DIV enabled cycles; the first BLANK cycles
// of every slot drive dark rows to suppress ghosting. New frames land in a
// shadow buffer and are promoted to the active buffer only when the scan
// wraps from the last column to column 0. Parameters must satisfy DIV >= 2
// and BLANK < DIV.
`timescale 1ns/1ps
module led_matrix_scanner #(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned COLS  = 7,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  led_matrix_scanner_if.slave   bus
);

  localparam int unsigned NPIX = ROWS * COLS;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DW   = $clog2(DIV);

  localparam logic [DW-1:0] CNT_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  // State
  logic [DW-1:0]   cnt_q,     cnt_d;
  logic [CW-1:0]   col_q,     col_d;
  logic [NPIX-1:0] active_q,  active_d;
  logic [NPIX-1:0] shadow_q,  shadow_d;
  logic            pending_q, pending_d;
  logic [ROWS-1:0] rows_q,    rows_d;
  logic [COLS-1:0] cols_q,    cols_d;
  logic            done_q,    done_d;

  // Decoded helpers
  logic            tick;
  logic            wrap;
  logic            lit;
  logic [ROWS-1:0] col_rows;
  logic [COLS-1:0] col_hot;

  // Prescaler terminal count and the frame-boundary tick.
  always_comb begin
    tick = bus.enable && (cnt_q == CNT_LAST);
    wrap = tick && (col_q == COL_LAST);
  end

  // Rows are lit once the blanking window of the slot has elapsed.
  if (BLANK == 0) begin : g_no_blank
    assign lit = 1'b1;
  end else begin : g_blank
    assign lit = (cnt_q >= DW'(BLANK));
  end

  // Column decode: pick the active-buffer slice and one-hot bit for col_q.
  // A compare per column keeps COLS non-power-of-2 safe.
  always_comb begin
    col_rows = '0;
    col_hot  = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (col_q == CW'(c)) begin
        col_rows   = active_q[c*ROWS +: ROWS];
        col_hot[c] = 1'b1;
      end
    end
  end

  // Prescaler and column counter; both freeze while disabled.
  always_comb begin
    cnt_d = cnt_q;
    col_d = col_q;
    if (bus.enable) begin
      cnt_d = tick ? '0 : cnt_q + DW'(1);
    end
    if (tick) begin
      col_d = wrap ? '0 : col_q + CW'(1);
    end
  end

  // Double buffer: the active frame only changes on a wrap tick. A load that
  // lands on the wrap tick itself goes straight to display.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (wrap) begin
      if (bus.load) begin
        active_d  = bus.frame_in;
        shadow_d  = bus.frame_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (bus.load) begin
      shadow_d  = bus.frame_in;
      pending_d = 1'b1;
    end
  end

  // Registered display outputs, one cycle behind the scan state.
  always_comb begin
    cols_d = bus.enable ? col_hot : '0;
    rows_d = (bus.enable && lit) ? col_rows : '0;
    done_d = wrap;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      col_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      done_q    <= done_d;
    end
  end

  assign bus.rows       = rows_q;
  assign bus.cols       = cols_q;
  assign bus.col_idx    = col_q;
  assign bus.frame_done = done_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed bench for led_matrix_scanner with
// ROWS=5, COLS=7, DIV=4, BLANK=1. kv counts enabled clock edges since the
// last reset; the expected scan position and display frame follow from it.
`timescale 1ns/1ps
module tb_led_matrix_scanner;

  localparam int unsigned ROWS  = 5;
  localparam int unsigned COLS  = 7;
  localparam int unsigned DIV   = 4;
  localparam int unsigned BLANK = 1;
  localparam int unsigned NPIX  = ROWS * COLS;
  localparam int unsigned FRAME = COLS * DIV;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  led_matrix_scanner #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DIV  (DIV),
    .BLANK(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int              n_checks = 0;
  int              n_pass   = 0;
  int              kv;
  int              swap_k;
  logic [NPIX-1:0] disp;
  logic [NPIX-1:0] pend_frame;
  logic [NPIX-1:0] f;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s kv=%0d got=%0h expected=%0h", tag, kv, got, exp);
  endtask

  function automatic logic [ROWS-1:0] col_of(input logic [NPIX-1:0] fr, input int c);
    return fr[c*ROWS +: ROWS];
  endfunction

  // One clock; checks outputs #1 after the edge against the kv-based model.
  task automatic cyc();
    logic            en;
    int              pk, pc, pcnt;
    logic [COLS-1:0] e_cols;
    logic [ROWS-1:0] e_rows;
    logic            e_done;
    @(posedge clk);
    en = bus.enable;
    if (en) begin
      kv++;
      if (kv - 1 == swap_k) disp = pend_frame;
    end
    #1;
    pk     = kv - 1;
    pc     = (pk / DIV) % COLS;
    pcnt   = pk % DIV;
    e_cols = '0;
    e_rows = '0;
    e_done = 1'b0;
    if (en) begin
      e_cols[pc] = 1'b1;
      if (pcnt >= BLANK) e_rows = col_of(disp, pc);
      e_done = (kv % FRAME == 0);
    end
    check_eq("cols",       64'(bus.cols),       64'(e_cols));
    check_eq("rows",       64'(bus.rows),       64'(e_rows));
    check_eq("frame_done", 64'(bus.frame_done), 64'(e_done));
    check_eq("col_idx",    64'(bus.col_idx),    64'((kv / DIV) % COLS));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".cols"},       64'(bus.cols),       64'(0));
    check_eq({tag, ".rows"},       64'(bus.rows),       64'(0));
    check_eq({tag, ".col_idx"},    64'(bus.col_idx),    64'(0));
    check_eq({tag, ".pending"},    64'(bus.pending),    64'(0));
    check_eq({tag, ".frame_done"}, 64'(bus.frame_done), 64'(0));
  endtask

  initial begin
    rst          = 1'b1;
    bus.enable   = 1'b0;
    bus.load     = 1'b0;
    bus.frame_in = '0;
    kv           = 0;
    swap_k       = -1;
    disp         = '0;
    pend_frame   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");

    // 1: free-running scan over an all-dark frame
    rst        = 1'b0;
    bus.enable = 1'b1;
    run(60);

    // 2: load column 2 = 10101, displayed from the next wrap (kv 84)
    f = '0;
    f[2*ROWS +: ROWS] = 5'b10101;
    bus.frame_in = f;
    bus.load     = 1'b1;
    cyc();
    bus.load     = 1'b0;
    bus.frame_in = '1;
    check_eq("t2.pending_set", 64'(bus.pending), 64'(1));
    pend_frame = f;
    swap_k     = 84;
    run(22);
    check_eq("t2.pending_hold", 64'(bus.pending), 64'(1));
    cyc();
    check_eq("t2.pending_clr", 64'(bus.pending), 64'(0));
    run(27);

    // 3: load on the wrap tick itself (kv 112) bypasses the shadow
    f = '0;
    f[0 +: ROWS] = 5'b11111;
    bus.frame_in = f;
    bus.load     = 1'b1;
    cyc();
    bus.load     = 1'b0;
    bus.frame_in = '1;
    check_eq("t3.pending", 64'(bus.pending), 64'(0));
    pend_frame = f;
    swap_k     = 112;
    run(10);

    // 4: frame A then frame B before the wrap; only B is ever shown
    bus.frame_in = '1;
    bus.load     = 1'b1;
    cyc();
    bus.load     = 1'b0;
    check_eq("t4.pending_a", 64'(bus.pending), 64'(1));
    run(2);
    f = '0;
    f[1*ROWS +: ROWS] = 5'b01010;
    f[4*ROWS +: ROWS] = 5'b10011;
    f[6*ROWS +: ROWS] = 5'b00001;
    bus.frame_in = f;
    bus.load     = 1'b1;
    cyc();
    bus.load     = 1'b0;
    bus.frame_in = '1;
    check_eq("t4.pending_b", 64'(bus.pending), 64'(1));
    pend_frame = f;
    swap_k     = 140;
    run(14);
    check_eq("t4.pending_clr", 64'(bus.pending), 64'(0));
    run(18);

    // 5: freeze at column 4, cnt 2 for 10 cycles, then resume
    check_eq("t5.col_idx", 64'(bus.col_idx), 64'(4));
    bus.enable = 1'b0;
    run(10);
    bus.enable = 1'b1;
    cyc();
    check_eq("t5.resume_rows", 64'(bus.rows), 64'(5'b10011));

    // 6: reset at column 5 with a frame pending
    bus.frame_in = '1;
    bus.load     = 1'b1;
    cyc();
    bus.load     = 1'b0;
    check_eq("t6.pending", 64'(bus.pending), 64'(1));
    check_eq("t6.col_idx", 64'(bus.col_idx), 64'(5));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("t6.reset");
    kv     = 0;
    swap_k = -1;
    disp   = '0;
    rst    = 1'b0;
    run(60);
    check_eq("t6.pending_after", 64'(bus.pending), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
